// File: rtl/smem_lsu.sv
// Warp-wide shared-memory load/store requester.
// One op in flight: filter, fire one multi-lane request, gather lanes, write back.
module smem_lsu #(
  parameter int WARP_SIZE      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TAG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic                             op_we,
  input  logic [WARP_SIZE-1:0]             op_mask,
  input  logic [WARP_SIZE*ADDR_WIDTH-1:0]  op_addr,
  input  logic [WARP_SIZE*DATA_WIDTH-1:0]  op_wdata,
  input  logic [TAG_WIDTH-1:0]             op_tag,
  output logic [WARP_SIZE-1:0]             mem_req_valid,
  output logic [WARP_SIZE-1:0]             mem_req_we,
  output logic [WARP_SIZE*ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [WARP_SIZE*DATA_WIDTH-1:0]  mem_req_wdata,
  output logic [WARP_SIZE-1:0]             mem_req_mask,
  input  logic                             mem_ready,
  input  logic [WARP_SIZE-1:0]             mem_resp_valid,
  input  logic [WARP_SIZE*DATA_WIDTH-1:0]  mem_resp_rdata,
  input  logic                             mem_conflict,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [WARP_SIZE*DATA_WIDTH-1:0]  wb_rdata,
  output logic [WARP_SIZE-1:0]             wb_mask,
  output logic [WARP_SIZE-1:0]             wb_err_mask,
  output logic [TAG_WIDTH-1:0]             wb_tag,
  output logic                             wb_timeout,
  output logic [31:0]                      stat_ops,
  output logic [31:0]                      stat_wait_cycles,
  output logic [31:0]                      stat_conflict_ops
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                          state;
  logic                            we_q;
  logic [WARP_SIZE*ADDR_WIDTH-1:0] addr_q;
  logic [WARP_SIZE*DATA_WIDTH-1:0] wdata_q;
  logic [TAG_WIDTH-1:0]            tag_q;
  logic [WARP_SIZE-1:0]            active_q;
  logic [WARP_SIZE-1:0]            err_q;
  logic [WARP_SIZE-1:0]            pending_q;
  logic [WARP_SIZE*DATA_WIDTH-1:0] rdata_q;
  logic [TW-1:0]                   tcnt;
  logic                            conf_q;
  logic                            tmo_q;

  logic [WARP_SIZE-1:0] aligned;
  logic [WARP_SIZE-1:0] hit;
  logic [WARP_SIZE-1:0] left;
  logic                 fire;
  logic                 done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    aligned = '0;
    for (int i = 0; i < WARP_SIZE; i++)
      aligned[i] = (op_addr[i*ADDR_WIDTH +: 2] == 2'b00);
  end

  assign fire = (state == ISSUE) && mem_ready;
  assign done = (state == DONE);
  assign hit  = mem_resp_valid & pending_q;
  assign left = pending_q & ~hit;

  // Request bus is zero except during the single fire cycle.
  always_comb begin
    mem_req_valid = '0;
    mem_req_we    = '0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (fire) begin
      mem_req_valid = active_q;
      mem_req_we    = {WARP_SIZE{we_q}};
      for (int i = 0; i < WARP_SIZE; i++) begin
        if (active_q[i]) begin
          mem_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
            addr_q[i*ADDR_WIDTH +: ADDR_WIDTH];
          mem_req_wdata[i*DATA_WIDTH +: DATA_WIDTH] =
            wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign mem_req_mask = mem_req_valid;
  assign op_ready     = (state == IDLE);
  assign wb_valid     = done;
  assign wb_mask      = done ? (active_q & ~err_q) : '0;
  assign wb_err_mask  = done ? err_q : '0;
  assign wb_tag       = done ? tag_q : '0;
  assign wb_timeout   = done && tmo_q;
  assign wb_rdata     = (done && !we_q) ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      tag_q             <= '0;
      active_q          <= '0;
      err_q             <= '0;
      pending_q         <= '0;
      rdata_q           <= '0;
      tcnt              <= '0;
      conf_q            <= 1'b0;
      tmo_q             <= 1'b0;
      stat_ops          <= '0;
      stat_wait_cycles  <= '0;
      stat_conflict_ops <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            we_q      <= op_we;
            addr_q    <= op_addr;
            wdata_q   <= op_wdata;
            tag_q     <= op_tag;
            active_q  <= op_mask & aligned;
            err_q     <= op_mask & ~aligned;
            pending_q <= '0;
            rdata_q   <= '0;
            tcnt      <= '0;
            conf_q    <= 1'b0;
            tmo_q     <= 1'b0;
            state     <= (|(op_mask & aligned)) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (mem_conflict) conf_q <= 1'b1;
          if (mem_ready) begin
            pending_q <= active_q;
            tcnt      <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_conflict) conf_q <= 1'b1;
          pending_q        <= left;
          stat_wait_cycles <= sat_inc(stat_wait_cycles);
          tcnt             <= tcnt + 1'b1;
          for (int i = 0; i < WARP_SIZE; i++) begin
            if (hit[i] && !we_q)
              rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                mem_resp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
          end
          if (left == '0) begin
            state <= DONE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q <= err_q | left;
            tmo_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (wb_ready) begin
            stat_ops <= sat_inc(stat_ops);
            if (conf_q) stat_conflict_ops <= sat_inc(stat_conflict_ops);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smem_lsu.sv
// Scoreboard bench for smem_lsu with a behavioural shared-memory model.
// Expected packets are queued at issue and popped at writeback.
module tb_smem_lsu;

  localparam int W   = 32;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_valid, op_ready, op_we;
  logic [W-1:0]    op_mask;
  logic [W*AW-1:0] op_addr;
  logic [W*DW-1:0] op_wdata;
  logic [TGW-1:0]  op_tag;
  logic [W-1:0]    mem_req_valid, mem_req_we, mem_req_mask;
  logic [W*AW-1:0] mem_req_addr;
  logic [W*DW-1:0] mem_req_wdata;
  logic            mem_ready;
  logic [W-1:0]    mem_resp_valid;
  logic [W*DW-1:0] mem_resp_rdata;
  logic            mem_conflict;
  logic            wb_valid, wb_ready, wb_timeout;
  logic [W*DW-1:0] wb_rdata;
  logic [W-1:0]    wb_mask, wb_err_mask;
  logic [TGW-1:0]  wb_tag;
  logic [31:0]     stat_ops, stat_wait_cycles, stat_conflict_ops;

  always #5 clk = ~clk;

  smem_lsu dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_we(op_we),
    .op_mask(op_mask), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_tag(op_tag),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_mask(mem_req_mask), .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_conflict(mem_conflict),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata),
    .wb_mask(wb_mask), .wb_err_mask(wb_err_mask), .wb_tag(wb_tag),
    .wb_timeout(wb_timeout),
    .stat_ops(stat_ops), .stat_wait_cycles(stat_wait_cycles),
    .stat_conflict_ops(stat_conflict_ops)
  );

  typedef struct {
    logic [W*DW-1:0] rdata;
    logic [W-1:0]    mask;
    logic [W-1:0]    err;
    logic [TGW-1:0]  tag;
    logic            tmo;
  } pkt_t;

  pkt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [AW-1:0] a_addr [W];
  logic [DW-1:0] a_data [W];
  logic [DW-1:0] ref_mem [16384];

  // Memory model: mode 0 answers all lanes next cycle, mode 1 one lane per cycle.
  int            mode = 0;
  logic [W-1:0]  drop = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] smem [16384];
  logic [W-1:0]  outst = '0;
  logic [AW-1:0] m_addr [W];
  logic          m_we = 1'b0;
  int            pulses = 0;
  logic [W-1:0]  last_req = '0;

  always @(negedge clk) begin
    logic [W-1:0] pick;
    pick = '0;
    mem_resp_valid = '0;
    for (int i = 0; i < W; i++)
      mem_resp_rdata[i*DW +: DW] = {16'hDEAD, 16'(i)};
    if (flush) outst = '0;
    if (mode == 1) begin
      for (int i = W - 1; i >= 0; i--)
        if (outst[i]) begin pick = '0; pick[i] = 1'b1; end
    end else begin
      pick = outst;
    end
    for (int i = 0; i < W; i++) begin
      if (pick[i]) begin
        mem_resp_valid[i] = 1'b1;
        if (!m_we) mem_resp_rdata[i*DW +: DW] = smem[m_addr[i][AW-1:2]];
      end
    end
    outst = outst & ~pick;
    if (|mem_req_valid) begin
      pulses++;
      last_req = mem_req_valid;
      m_we = mem_req_we[0];
      for (int i = 0; i < W; i++) begin
        if (mem_req_valid[i]) begin
          m_addr[i] = mem_req_addr[i*AW +: AW];
          if (mem_req_we[i] && !drop[i])
            smem[m_addr[i][AW-1:2]] = mem_req_wdata[i*DW +: DW];
        end
      end
      outst = outst | (mem_req_valid & ~drop);
    end
  end

  function automatic pkt_t model(logic we, logic [W-1:0] mask,
                                 logic [TGW-1:0] tag);
    pkt_t p;
    logic [W-1:0] act;
    p.rdata = '0;
    p.tag = tag;
    for (int i = 0; i < W; i++)
      act[i] = mask[i] && (a_addr[i][1:0] == 2'b00);
    p.err  = (mask & ~act) | (act & drop);
    p.tmo  = |(act & drop);
    p.mask = act & ~p.err;
    for (int i = 0; i < W; i++) begin
      if (p.mask[i]) begin
        if (we) ref_mem[a_addr[i][AW-1:2]] = a_data[i];
        else p.rdata[i*DW +: DW] = ref_mem[a_addr[i][AW-1:2]];
      end
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic we, logic [W-1:0] mask, logic [TGW-1:0] tag);
    int n = 0;
    while (!op_ready && n < 200) begin tick(); n++; end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: op_ready=%b required 1", op_ready);
    end
    op_valid = 1'b1;
    op_we    = we;
    op_mask  = mask;
    op_tag   = tag;
    for (int i = 0; i < W; i++) begin
      op_addr[i*AW +: AW]  = a_addr[i];
      op_wdata[i*DW +: DW] = a_data[i];
    end
    sb.push_back(model(we, mask, tag));
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (!wb_valid && n < 300) begin tick(); n++; end
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL wb_wait: wb_valid=%b required 1 after %0d cycles",
               wb_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (op_ready !== 1'b1 || wb_valid !== 1'b0 || mem_req_valid !== '0 ||
        stat_ops !== 0 || stat_wait_cycles !== 0 || stat_conflict_ops !== 0) begin
      errors++;
      $display("FAIL reset: op_ready=%b wb_valid=%b req=%h ops=%0d required 1 0 0 0",
               op_ready, wb_valid, mem_req_valid, stat_ops);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stride();
    pkt_t e;
    int   n;
    for (int i = 0; i < W; i++) begin
      a_addr[i] = AW'(4 * i);
      a_data[i] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 2; k++) begin
      send(k == 0, '1, TGW'(3 + k));
      wait_wb(n);
      e = sb.pop_front();
      checks++;
      if (wb_rdata !== e.rdata || wb_mask !== e.mask || wb_err_mask !== e.err ||
          wb_tag !== e.tag || wb_timeout !== e.tmo) begin
        errors++;
        $display("FAIL stride_%0d: mask=%h err=%h tag=%0d rd0=%h required %h %h %0d %h",
                 k, wb_mask, wb_err_mask, wb_tag, wb_rdata[31:0],
                 e.mask, e.err, e.tag, e.rdata[31:0]);
      end
      tick();
    end
    checks++;
    if (stat_ops !== 32'd2 || stat_wait_cycles !== 32'd2) begin
      errors++;
      $display("FAIL stride_stats: ops=%0d wait=%0d required 2 2",
               stat_ops, stat_wait_cycles);
    end
  endtask

  task automatic test_conflict();
    pkt_t        e;
    int          n;
    int          extra = 0;
    logic [31:0] w0;
    w0 = stat_wait_cycles;
    mode = 1;
    mem_conflict = 1'b1;
    send(1'b0, '1, 5'd7);
    wait_wb(n);
    e = sb.pop_front();
    checks++;
    if (wb_rdata !== e.rdata || wb_mask !== e.mask || wb_err_mask !== e.err ||
        wb_tag !== e.tag) begin
      errors++;
      $display("FAIL conflict_wb: mask=%h rd31=%h required %h %h",
               wb_mask, wb_rdata[31*DW +: DW], e.mask, e.rdata[31*DW +: DW]);
    end
    checks++;
    if (stat_wait_cycles - w0 !== 32'd32) begin
      errors++;
      $display("FAIL conflict_wait: delta=%0d required 32", stat_wait_cycles - w0);
    end
    mem_conflict = 1'b0;
    tick();
    repeat (5) begin
      if (wb_valid) extra++;
      tick();
    end
    checks++;
    if (extra !== 0 || stat_conflict_ops !== 32'd1) begin
      errors++;
      $display("FAIL conflict_stats: extra_wb=%0d cops=%0d required 0 1",
               extra, stat_conflict_ops);
    end
    mode = 0;
  endtask

  task automatic test_misalign();
    pkt_t e;
    int   n;
    a_addr[2] = 16'h0006;
    send(1'b0, 32'h5555_5555, 5'd11);
    wait_wb(n);
    e = sb.pop_front();
    checks++;
    if (last_req !== 32'h5555_5551) begin
      errors++;
      $display("FAIL misalign_req: req=%h required 55555551", last_req);
    end
    checks++;
    if (wb_mask !== e.mask || wb_err_mask !== 32'h0000_0004 ||
        wb_rdata !== e.rdata || wb_tag !== e.tag) begin
      errors++;
      $display("FAIL misalign_wb: mask=%h err=%h required %h 00000004",
               wb_mask, wb_err_mask, e.mask);
    end
    tick();
    a_addr[2] = 16'h0008;
  endtask

  task automatic test_mem_stall();
    pkt_t e;
    int   n;
    int   p0;
    int   bad = 0;
    for (int i = 0; i < W; i++) a_data[i] = 32'hB000_0000 + 32'(i);
    p0 = pulses;
    mem_ready = 1'b0;
    send(1'b1, '1, 5'd20);
    repeat (10) begin
      if (mem_req_valid !== '0 || op_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || pulses !== p0) begin
      errors++;
      $display("FAIL stall_hold: bad_cycles=%0d pulses=%0d required 0 0",
               bad, pulses - p0);
    end
    mem_ready = 1'b1;
    wait_wb(n);
    e = sb.pop_front();
    checks++;
    if (pulses - p0 !== 1 || wb_mask !== e.mask || wb_rdata !== e.rdata) begin
      errors++;
      $display("FAIL stall_fire: pulses=%0d mask=%h required 1 %h",
               pulses - p0, wb_mask, e.mask);
    end
    tick();
  endtask

  task automatic test_timeout();
    pkt_t        e;
    int          n;
    logic [31:0] w0;
    w0 = stat_wait_cycles;
    drop = 32'h0000_0080;
    wb_ready = 1'b0;
    send(1'b0, '1, 5'd9);
    wait_wb(n);
    e = sb.pop_front();
    checks++;
    if (stat_wait_cycles - w0 !== 32'd64) begin
      errors++;
      $display("FAIL timeout_wait: delta=%0d required 64", stat_wait_cycles - w0);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_timeout !== 1'b1 || wb_err_mask !== 32'h80 ||
          wb_mask !== 32'hFFFF_FF7F || wb_rdata !== e.rdata ||
          wb_tag !== e.tag) begin
        errors++;
        $display("FAIL timeout_hold_%0d: v=%b tmo=%b err=%h mask=%h required 1 1 80 ffffff7f",
                 k, wb_valid, wb_timeout, wb_err_mask, wb_mask);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    drop = '0;
  endtask

  task automatic test_reset_mid();
    pkt_t e;
    int   n;
    int   seen = 0;
    mode = 1;
    send(1'b0, '1, 5'd2);
    sb.delete();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (op_ready !== 1'b1 || wb_valid !== 1'b0 || stat_ops !== 0 ||
        stat_wait_cycles !== 0 || stat_conflict_ops !== 0) begin
      errors++;
      $display("FAIL rst_mid: op_ready=%b wb_valid=%b ops=%0d wait=%0d required 1 0 0 0",
               op_ready, wb_valid, stat_ops, stat_wait_cycles);
    end
    rst = 1'b0;
    repeat (40) begin
      if (wb_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_abandon: wb_cycles=%0d required 0", seen);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mode = 0;
    send(1'b0, '1, 5'd30);
    wait_wb(n);
    e = sb.pop_front();
    checks++;
    if (wb_rdata !== e.rdata || wb_mask !== e.mask || wb_tag !== e.tag) begin
      errors++;
      $display("FAIL rst_recover: mask=%h rd0=%h required %h %h",
               wb_mask, wb_rdata[31:0], e.mask, e.rdata[31:0]);
    end
    tick();
    checks++;
    if (stat_ops !== 32'd1) begin
      errors++;
      $display("FAIL rst_recover_ops: ops=%0d required 1", stat_ops);
    end
  endtask

  initial begin
    op_valid     = 1'b0;
    op_we        = 1'b0;
    op_mask      = '0;
    op_addr      = '0;
    op_wdata     = '0;
    op_tag       = '0;
    mem_ready    = 1'b1;
    mem_conflict = 1'b0;
    wb_ready     = 1'b1;
    test_reset();
    test_stride();
    test_conflict();
    test_misalign();
    test_mem_stall();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
